return_stack: RTL and testbench

RETURN_STACK -- requirements
Module: return_stack

---
 rtl/return_stack_if.sv | 30 +++
 rtl/return_stack.sv | 94 +++++++++
 tb/tb_return_stack.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/return_stack_if.sv
`default_nettype none
// ============================================================================
//  Module      : return_stack_if
//  Description : Call/return handshake and status bundle for return_stack.
//  Revision    : 1.0 - initial release
// ============================================================================
interface return_stack_if;
    logic       push;
    logic       pop;
    logic [7:0] dataIn;
    logic       clearErr;
    logic [7:0] retAddr;
    logic       retValid;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    modport master (
        output push, pop, dataIn, clearErr,
        input  retAddr, retValid, empty, full, count, overflow, underflow
    );

    modport slave (
        input  push, pop, dataIn, clearErr,
        output retAddr, retValid, empty, full, count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/return_stack.sv
`default_nettype none
// ============================================================================
//  Module      : return_stack
//  Description : DEPTH-entry LIFO of 8-bit subroutine return addresses with
//                registered pop output and sticky overflow/underflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module return_stack #(
    parameter int DEPTH = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
    return_stack_if.slave  bus
);
    localparam int         c_IDX_W = $clog2(DEPTH);
    localparam logic [3:0] c_DEPTH = 4'(DEPTH);

    logic [7:0]         r_entry [DEPTH];
    logic [3:0]         r_count;
    logic [7:0]         r_retAddr;
    logic               r_retValid;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_empty;
    logic               w_full;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_top_idx;

    assign w_empty   = (r_count == 4'd0);
    assign w_full    = (r_count == c_DEPTH);
    // Truncation makes count==DEPTH wrap to 0 for power-of-two depths, so
    // subtracting one still lands on the top entry.
    assign w_wr_idx  = r_count[c_IDX_W-1:0];
    assign w_top_idx = w_wr_idx - 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= 4'd0;
            r_retAddr   <= 8'h00;
            r_retValid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= 8'h00;
            end
        end else begin
            r_retValid <= 1'b0;
            // Clear first so a same-cycle refused push/pop below takes priority.
            if (bus.clearErr) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end
            case ({bus.push, bus.pop})
                2'b10: begin
                    if (!w_full) begin
                        r_entry[w_wr_idx] <= bus.dataIn;
                        r_count           <= r_count + 4'd1;
                    end else begin
                        r_overflow <= 1'b1;
                    end
                end
                2'b01: begin
                    if (!w_empty) begin
                        r_retAddr  <= r_entry[w_top_idx];
                        r_count    <= r_count - 4'd1;
                        r_retValid <= 1'b1;
                    end else begin
                        r_underflow <= 1'b1;
                    end
                end
                2'b11: begin
                    r_retValid <= 1'b1;
                    if (!w_empty) begin
                        r_retAddr           <= r_entry[w_top_idx];
                        r_entry[w_top_idx]  <= bus.dataIn;
                    end else begin
                        r_retAddr <= bus.dataIn;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.retAddr   = r_retAddr;
    assign bus.retValid  = r_retValid;
    assign bus.count     = r_count;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_return_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_return_stack
//  Description : Directed plus random stimulus against a queue-based LIFO model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_return_stack;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    return_stack_if bus ();

    return_stack #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] q[$];
    logic [7:0] m_ret;
    logic       m_valid;
    logic       m_ovf;
    logic       m_unf;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ret   = 8'h00;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic o, input logic [7:0] d, input logic c);
        logic set_ovf;
        logic set_unf;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        m_valid = 1'b0;
        if (p && !o) begin
            if (q.size() < DEPTH) q.push_back(d);
            else set_ovf = 1'b1;
        end else if (o && !p) begin
            if (q.size() > 0) begin
                m_ret   = q.pop_back();
                m_valid = 1'b1;
            end else set_unf = 1'b1;
        end else if (p && o) begin
            m_valid = 1'b1;
            if (q.size() > 0) begin
                m_ret = q[q.size()-1];
                q[q.size()-1] = d;
            end else m_ret = d;
        end
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (set_ovf) m_ovf = 1'b1;
        if (set_unf) m_unf = 1'b1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},     8'(bus.count),     8'(q.size()));
        check({tag, ".empty"},     8'(bus.empty),     8'(q.size() == 0));
        check({tag, ".full"},      8'(bus.full),      8'(q.size() == DEPTH));
        check({tag, ".retAddr"},   bus.retAddr,       m_ret);
        check({tag, ".retValid"},  8'(bus.retValid),  8'(m_valid));
        check({tag, ".overflow"},  8'(bus.overflow),  8'(m_ovf));
        check({tag, ".underflow"}, 8'(bus.underflow), 8'(m_unf));
    endtask

    task automatic cyc(input string tag, input logic p, input logic o,
                       input logic [7:0] d, input logic c);
        @(negedge clk);
        bus.push = p; bus.pop = o; bus.dataIn = d; bus.clearErr = c;
        @(posedge clk);
        model_step(p, o, d, c);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.dataIn = 8'h00; bus.clearErr = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Basic LIFO order
        cyc("push12", 1, 0, 8'h12, 0);
        cyc("push34", 1, 0, 8'h34, 0);
        cyc("push56", 1, 0, 8'h56, 0);
        check("three.count", 8'(bus.count), 8'd3);
        cyc("pop1", 0, 1, 8'h00, 0);
        check("pop1.lit", bus.retAddr, 8'h56);
        cyc("pop2", 0, 1, 8'h00, 0);
        check("pop2.lit", bus.retAddr, 8'h34);
        cyc("pop3", 0, 1, 8'h00, 0);
        check("pop3.lit", bus.retAddr, 8'h12);
        cyc("idle", 0, 0, 8'h00, 0);
        check("idle.empty", 8'(bus.empty), 8'd1);

        // Fill and overflow
        for (int i = 0; i < 5; i++) cyc("fill", 1, 0, 8'hA0 + 8'(i), 0);
        check("ovf.lit", 8'(bus.overflow), 8'd1);
        cyc("ovfpop", 0, 1, 8'h00, 0);
        check("ovfpop.lit", bus.retAddr, 8'hA3);
        cyc("refill", 1, 0, 8'hB3, 0);
        cyc("fullswap", 1, 1, 8'hC4, 0);
        cyc("clrovf", 0, 0, 8'h00, 1);
        for (int i = 0; i < 4; i++) cyc("drain", 0, 1, 8'h00, 0);

        // Underflow and clear priority
        cyc("unf", 0, 1, 8'h00, 0);
        cyc("unfclr", 0, 0, 8'h00, 1);
        cyc("unfsetwins", 0, 1, 8'h00, 1);
        check("setwins.lit", 8'(bus.underflow), 8'd1);
        cyc("clr2", 0, 0, 8'h00, 1);

        // Simultaneous push/pop
        cyc("p10", 1, 0, 8'h10, 0);
        cyc("p20", 1, 0, 8'h20, 0);
        cyc("swap", 1, 1, 8'h99, 0);
        check("swap.lit", bus.retAddr, 8'h20);
        cyc("swappop", 0, 1, 8'h00, 0);
        check("swappop.lit", bus.retAddr, 8'h99);
        cyc("pop10", 0, 1, 8'h00, 0);
        cyc("bypass", 1, 1, 8'h77, 0);
        check("bypass.lit", bus.retAddr, 8'h77);

        // Asynchronous reset between edges with a push pending
        cyc("r1", 1, 0, 8'h01, 0);
        cyc("r2", 1, 0, 8'h02, 0);
        cyc("r3", 1, 0, 8'h03, 1);
        cyc("rpop", 0, 1, 8'h00, 0);
        cyc("r4", 1, 0, 8'h04, 0);
        @(negedge clk);
        bus.push = 1'b1; bus.pop = 1'b0; bus.dataIn = 8'hEE;
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_all("asyncrst");
        @(posedge clk);
        #1;
        check_all("rstedge");
        @(negedge clk);
        reset = 1'b0;
        bus.push = 1'b0;
        cyc("postrst", 0, 1, 8'h00, 0);
        cyc("postrst2", 1, 0, 8'h5A, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            cyc("rand", r[0] | r[1], r[2], 8'($urandom), (r == 4'hF));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
